fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Fetch stage fed by the 4-phase CPU sequencer (state: 0=fetch, 1=decode, 2=execute, 3=store).
//  Holds the PC and the instruction register (IR), and runs the instruction-memory handshake in fetch.
//  Advances the PC (sequential or branch) once per store phase.
//  Drives IR/PC to decode/execute and reports fetch stalls and faults.
// PARAMETERS
//  ADDR_W    8      PC / instruction address width (word addressed)
//  DATA_W    16     instruction width
//  RESET_PC  0      PC value after reset
//  TIMEOUT   15     max cycles to wait for imem_valid before fault (1..255)
//  NOP_INSTR 16'h0  IR value loaded on fetch fault
// PORTS
//  clk            in   1       clock, all logic on posedge
//  reset          in   1       synchronous, active-low (reset==0 resets)
//  state          in   2       sequencer phase
//  branch_taken   in   1       execute result, sampled in store
//  branch_target  in   ADDR_W  target PC, sampled with branch_taken
//  imem_req       out  1       read request, 1-cycle pulse
//  imem_addr      out  ADDR_W  read address, valid while imem_req==1
//  imem_rdata     in   DATA_W  read data, valid with imem_valid
//  imem_valid     in   1       read data strobe
//  pc             out  ADDR_W  current PC
//  instr          out  DATA_W  instruction register
//  instr_valid    out  1       IR holds the word fetched for the current pc
//  stall          out  1       fetch outstanding; future sequencer holds phase
//  fetch_fault    out  1       sticky; a fetch timed out; cleared only by reset
// BEHAVIOUR
//  Reset (reset==0 at posedge):
//   - pc=RESET_PC, instr=NOP_INSTR.
//   - instr_valid=0, stall=0, fetch_fault=0, imem_req=0.
//   - FSM=IDLE, prev_state=3, boot=1.
//  Phase entry means state!=prev_state; prev_state is registered every cycle.
//  FSM states:
//   - IDLE: on entry to phase 0, imem_req=1 and imem_addr=pc for exactly 1 cycle; go to WAIT; clear instr_valid.
//   - WAIT: stall=1; count cycles from 1 up.
//     - On imem_valid: instr<=imem_rdata, instr_valid<=1, go to DONE; stall drops the next cycle.
//     - If count reaches TIMEOUT without imem_valid: instr<=NOP_INSTR, instr_valid<=1, fetch_fault<=1, go to DONE.
//   - DONE: leave to IDLE on entry to phase 3 (store).
//  Latency: imem_valid in cycle N gives instr/instr_valid updated at posedge N+1.
//   imem_valid in the request cycle itself is accepted (0-wait memory).
//  Phase 0 entry outside IDLE (sequencer not stalled): abandon the old fetch, issue a new request, restart the timeout counter.
//  imem_valid outside WAIT is ignored.
//  PC update, on store entry only:
//   - boot==1: pc unchanged, boot<=0 (the sequencer resets into store).
//   - branch_taken==1: pc<=branch_target.
//   - else pc<=pc+1, wrapping from 2^ADDR_W-1 to 0 with no flag.
//  Store phase lasting >1 cycle: PC still updates once.
//  Reset mid-fetch: the request is dropped; a late imem_valid after reset is ignored (FSM=IDLE).
//  branch_taken/branch_target are ignored outside store entry.
//  Skipped phase (state 3->1): no fetch is issued; IR keeps its old value with instr_valid=0.
// TESTING
//  1. Reset, step phases 3,0,1,2,3,0 with imem_valid on the request cycle -> first fetch addr 0, second addr 1, pc=1.
//  2. imem_valid 3 cycles after imem_req, rdata=16'hA5C3 -> stall=1 for 3 cycles, instr=16'hA5C3, instr_valid=1, fetch_fault=0.
//  3. No imem_valid, TIMEOUT=15 -> fault after 15 WAIT cycles, instr=NOP_INSTR, fetch_fault=1 held until reset.
//  4. branch_taken=1, target=8'h40 at store entry -> next imem_addr=8'h40; pc=8'hFF without branch -> pc wraps to 0.
//  5. reset=0 during WAIT, then late imem_valid -> FSM IDLE, instr=NOP_INSTR, instr_valid=0, no fault, pc=RESET_PC.
//  6. Store held 4 cycles with pc=5 -> pc=6 exactly once; first store after reset leaves pc=RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: PC/IR holder running the instruction-memory handshake in the fetch phase of a 4-phase sequencer
module fetch_unit #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int TIMEOUT = 15,
  parameter logic [DATA_W-1:0] NOP_INSTR = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        state,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              imem_valid,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  output logic              stall,
  output logic              fetch_fault
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} fsm_t;
  localparam logic [7:0] TO = 8'(TIMEOUT);
  fsm_t fsm, fsm_nx;
  logic [1:0] prev_state;
  logic boot;
  logic [7:0] cnt, cnt_nx;
  logic fetch, store, hit, expire;
  always_comb begin
    fetch = state == 2'd0 && prev_state != 2'd0;
    store = state == 2'd3 && prev_state != 2'd3;
    hit = imem_valid && (fetch || fsm == S_WAIT);
    expire = !fetch && fsm == S_WAIT && !imem_valid && cnt == TO;
    fsm_nx = fetch ? (imem_valid ? S_DONE : S_WAIT) :
             fsm == S_WAIT ? (hit || expire ? S_DONE : S_WAIT) :
             fsm == S_DONE && store ? S_IDLE : fsm;
    cnt_nx = fetch ? 8'd1 : fsm == S_WAIT ? cnt + 8'd1 : cnt;
  end
  // the boot store is the one the sequencer sits in straight out of reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      fsm <= S_IDLE;
      prev_state <= 2'd3;
      boot <= 1'b1;
      cnt <= '0;
      pc <= RESET_PC;
      instr <= NOP_INSTR;
      instr_valid <= 1'b0;
      fetch_fault <= 1'b0;
    end else begin
      fsm <= fsm_nx;
      prev_state <= state;
      cnt <= cnt_nx;
      if (hit) instr <= imem_rdata;
      else if (expire) instr <= NOP_INSTR;
      if (hit || expire) instr_valid <= 1'b1;
      else if (fetch || store) instr_valid <= 1'b0;
      if (expire) fetch_fault <= 1'b1;
      if (state == 2'd3 && boot) boot <= 1'b0;
      else if (store) pc <= branch_taken ? branch_target : pc + ADDR_W'(1);
    end
  end
  assign imem_req = fetch && reset;
  assign imem_addr = pc;
  assign stall = fsm == S_WAIT;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed phase sequences with a request-address scoreboard and immediate-assertion checks
module tb_fetch_unit;
  logic clk = 1'b0;
  logic reset, branch_taken, imem_valid, imem_req, instr_valid, stall, fetch_fault;
  logic [1:0] state;
  logic [7:0] branch_target, imem_addr, pc;
  logic [15:0] imem_rdata, instr;
  int vectors = 0;
  int miscompares = 0;
  logic [7:0] q[$];

  fetch_unit dut (
    .clk(clk), .reset(reset), .state(state), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_valid(imem_valid), .pc(pc), .instr(instr),
    .instr_valid(instr_valid), .stall(stall), .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic [1:0] s, input logic v, input logic [15:0] d);
    @(negedge clk);
    state = s;
    imem_valid = v;
    imem_rdata = d;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    #4;
    if (imem_req) begin
      if (q.size() == 0) check("spurious_req", imem_req, 1'b0);
      else check("imem_addr", imem_addr, q.pop_front());
    end
  end

  initial begin
    int n;
    reset = 1'b0; state = 2'd3; branch_taken = 1'b0; branch_target = '0;
    imem_valid = 1'b0; imem_rdata = '0;
    cyc(3, 0, 0); cyc(3, 0, 0);
    check("rst_pc", pc, 8'h00);
    check("rst_instr", instr, 16'h0000);
    check("rst_ivalid", instr_valid, 1'b0);
    check("rst_stall", stall, 1'b0);
    check("rst_fault", fetch_fault, 1'b0);
    check("rst_req", imem_req, 1'b0);
    reset = 1'b1;
    cyc(3, 0, 0);
    q.push_back(8'h00); cyc(0, 1, 16'h1111);
    check("t1_instr0", instr, 16'h1111);
    check("t1_ivalid0", instr_valid, 1'b1);
    check("t1_stall0", stall, 1'b0);
    cyc(1, 0, 0); cyc(2, 0, 0); cyc(3, 0, 0);
    check("t1_pc", pc, 8'h01);
    check("t1_ivalid_store", instr_valid, 1'b0);
    q.push_back(8'h01); cyc(0, 1, 16'h2222);
    check("t1_instr1", instr, 16'h2222);
    cyc(1, 0, 0); cyc(2, 0, 0); cyc(3, 0, 0);
    check("t2_pc", pc, 8'h02);
    q.push_back(8'h02); cyc(0, 0, 0);
    n = 0;
    for (int i = 0; i < 3; i++) begin
      if (stall) n++;
      cyc(0, i == 2, 16'hA5C3);
    end
    check("t2_stall_cycles", n, 3);
    check("t2_stall_drop", stall, 1'b0);
    check("t2_instr", instr, 16'hA5C3);
    check("t2_ivalid", instr_valid, 1'b1);
    check("t2_fault", fetch_fault, 1'b0);
    cyc(1, 0, 0); cyc(2, 0, 0); cyc(3, 0, 0);
    check("t3_pc", pc, 8'h03);
    q.push_back(8'h03); cyc(0, 0, 0);
    n = 0;
    while (stall && n < 40) begin
      n++;
      cyc(0, 0, 0);
    end
    check("t3_wait_cycles", n, 15);
    check("t3_instr_nop", instr, 16'h0000);
    check("t3_ivalid", instr_valid, 1'b1);
    check("t3_fault", fetch_fault, 1'b1);
    cyc(0, 1, 16'hDEAD);
    check("t3_late_valid", instr, 16'h0000);
    branch_taken = 1'b1; branch_target = 8'h77; cyc(1, 0, 0);
    branch_taken = 1'b0; cyc(2, 0, 0);
    branch_taken = 1'b1; branch_target = 8'h40; cyc(3, 0, 0);
    branch_taken = 1'b0;
    check("t4_branch_pc", pc, 8'h40);
    q.push_back(8'h40); cyc(0, 1, 16'h3333);
    check("t4_instr", instr, 16'h3333);
    check("t4_fault_sticky", fetch_fault, 1'b1);
    cyc(1, 0, 0); cyc(2, 0, 0);
    branch_taken = 1'b1; branch_target = 8'hFF; cyc(3, 0, 0);
    branch_taken = 1'b0;
    check("t4_pc_ff", pc, 8'hFF);
    q.push_back(8'hFF); cyc(0, 1, 16'h4444);
    cyc(1, 0, 0); cyc(2, 0, 0); cyc(3, 0, 0);
    check("t4_wrap", pc, 8'h00);
    q.push_back(8'h00); cyc(0, 1, 16'h5555);
    cyc(1, 0, 0); cyc(2, 0, 0);
    branch_taken = 1'b1; branch_target = 8'h05; cyc(3, 0, 0);
    branch_taken = 1'b0;
    check("t6_pc5", pc, 8'h05);
    q.push_back(8'h05); cyc(0, 1, 16'h6666);
    cyc(1, 0, 0); cyc(2, 0, 0);
    for (int i = 0; i < 4; i++) begin
      branch_taken = i > 0; branch_target = 8'h99;
      cyc(3, 0, 0);
      check("t6_store_hold", pc, 8'h06);
    end
    branch_taken = 1'b0;
    cyc(1, 0, 0);
    check("skip_instr", instr, 16'h6666);
    check("skip_ivalid", instr_valid, 1'b0);
    cyc(2, 0, 0); cyc(3, 0, 0);
    check("skip_pc", pc, 8'h07);
    q.push_back(8'h07); cyc(0, 0, 0);
    check("t5_stall", stall, 1'b1);
    reset = 1'b0; cyc(3, 0, 0);
    reset = 1'b1; cyc(3, 1, 16'hBEEF);
    check("t5_instr", instr, 16'h0000);
    check("t5_ivalid", instr_valid, 1'b0);
    check("t5_fault", fetch_fault, 1'b0);
    check("t5_stall_idle", stall, 1'b0);
    check("t5_pc", pc, 8'h00);
    reset = 1'b0; cyc(3, 0, 0);
    reset = 1'b1;
    q.push_back(8'h00); cyc(0, 1, 16'h7777);
    cyc(1, 0, 0); cyc(2, 0, 0); cyc(3, 0, 0);
    check("t6_boot_pc", pc, 8'h00);
    q.push_back(8'h00); cyc(0, 1, 16'h8888);
    check("t6_boot_instr", instr, 16'h8888);
    cyc(1, 0, 0); cyc(2, 0, 0); cyc(3, 0, 0);
    check("t6_after_boot_pc", pc, 8'h01);
    cyc(1, 0, 0);
    check("sb_drain", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
